// File: rtl/mem_access_unit_if.sv
// Request, data-bus and writeback signals of the MEM stage.
// master: the MEM-stage unit; slave: the EX/MEM register, data bus and WB side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_op;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_wdata;
  logic                flush;

  logic                dbus_valid;
  logic [ADDR_W-1:0]   dbus_addr;
  logic [2:0]          dbus_size;
  logic [DATA_W/8-1:0] dbus_strobe;
  logic [DATA_W-1:0]   dbus_wdata;
  logic                dbus_data_ok;
  logic [DATA_W-1:0]   dbus_rdata;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_misalign;

  modport master (
    input  in_valid, in_op, in_addr, in_wdata, flush,
    input  dbus_data_ok, dbus_rdata, out_ready,
    output in_ready, dbus_valid, dbus_addr, dbus_size, dbus_strobe, dbus_wdata,
    output out_valid, out_data, out_misalign
  );

  modport slave (
    output in_valid, in_op, in_addr, in_wdata, flush,
    output dbus_data_ok, dbus_rdata, out_ready,
    input  in_ready, dbus_valid, dbus_addr, dbus_size, dbus_strobe, dbus_wdata,
    input  out_valid, out_data, out_misalign
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer; define MEM_MISALIGN_TRAP_EN to trap misaligned ops instead of issuing them.
// Latency: accept to out_valid is 1 cycle for pass-through/trap, 2 cycles plus bus wait states for loads/stores.
// Backpressure: in_ready only in IDLE or in DONE with out_ready; the result is held in DONE until out_ready.
module mem_access_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic               clk,
  input logic               reset_n,
  mem_access_unit_if.master bus
);
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LD  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_LHU = 4'd6;
  localparam logic [3:0] OP_LWU = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;
  localparam logic [3:0] OP_SD  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_DRAIN} state_t;

  state_t            state_q;
  logic [3:0]        op_q;
  logic              dbus_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [7:0]        strobe_q;
  logic [DATA_W-1:0] wdata_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              misalign_q;

  logic              in_ready;
  logic              accept;
  logic              is_load_d;
  logic              is_store_d;
  logic              trap_d;
  logic [2:0]        off_d;
  logic [2:0]        size_d;
  logic [3:0]        nbytes_d;
  logic [7:0]        strobe_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] load_ext;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign off_d    = bus.in_addr[2:0];

  always_comb begin
    is_load_d  = (bus.in_op >= OP_LB) && (bus.in_op <= OP_LWU);
    is_store_d = (bus.in_op >= OP_SB) && (bus.in_op <= OP_SD);
    size_d     = 3'd0;
    case (bus.in_op)
      OP_LH, OP_LHU, OP_SH: size_d = 3'd1;
      OP_LW, OP_LWU, OP_SW: size_d = 3'd2;
      OP_LD, OP_SD:         size_d = 3'd3;
      default:              size_d = 3'd0;
    endcase
    nbytes_d = 4'd1 << size_d;
    // Lanes past byte 7 simply drop out of the strobe.
    for (int i = 0; i < 8; i++) begin
      strobe_d[i] = is_store_d && (4'(i) >= {1'b0, off_d}) && (4'(i) < ({1'b0, off_d} + nbytes_d));
    end
    wdata_d = '0;
    if (is_store_d) begin
      wdata_d = (bus.in_op == OP_SD) ? bus.in_wdata : (bus.in_wdata << {off_d, 3'b000});
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_d = (is_load_d || is_store_d) && (|(off_d & (nbytes_d[2:0] - 3'd1)));
`else
  assign trap_d = 1'b0;
`endif

  // Zero-filling shift makes lanes beyond byte 7 read as 0 for misaligned loads.
  assign rd_shift = bus.dbus_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = rd_shift;
    case (op_q)
      OP_LB:   load_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
      OP_LH:   load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
      OP_LW:   load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
      OP_LBU:  load_ext = {56'd0, rd_shift[7:0]};
      OP_LHU:  load_ext = {48'd0, rd_shift[15:0]};
      OP_LWU:  load_ext = {32'd0, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      dbus_valid_q <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      strobe_q     <= '0;
      wdata_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
          end else if (accept) begin
            op_q       <= bus.in_op;
            misalign_q <= trap_d;
            if ((is_load_d || is_store_d) && !trap_d) begin
              state_q      <= S_REQ;
              dbus_valid_q <= 1'b1;
              addr_q       <= bus.in_addr;
              size_q       <= size_d;
              strobe_q     <= strobe_d;
              wdata_q      <= wdata_d;
              out_valid_q  <= 1'b0;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= trap_d ? bus.in_addr[DATA_W-1:0] : bus.in_wdata;
            end
          end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
          end
        end
        S_REQ: begin
          if (bus.dbus_data_ok) begin
            dbus_valid_q <= 1'b0;
            if (bus.flush) begin
              state_q <= S_IDLE;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= (op_q >= OP_SB) ? '0 : load_ext;
            end
          end else if (bus.flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The bus cannot be abandoned mid-transfer; wait out the response silently.
          if (bus.dbus_data_ok) begin
            dbus_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.dbus_valid   = dbus_valid_q;
  assign bus.dbus_addr    = addr_q;
  assign bus.dbus_size    = size_q;
  assign bus.dbus_strobe  = strobe_q;
  assign bus.dbus_wdata   = wdata_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_misalign = misalign_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases then randomized ops against a byte-level reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(64), .DATA_W(64)) bus ();
  mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic [63:0] data;
    logic        mis;
  } res_t;

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic        is_store;
    logic [63:0] rdata;
    int          delay;
  } breq_t;

  res_t  exp_q[$];
  breq_t bus_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    rdy_rand = 1'b0;
  logic  rdy_fixed = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd5, 4'd8:  return 1;
      4'd2, 4'd6, 4'd9:  return 2;
      4'd3, 4'd7, 4'd10: return 4;
      4'd4, 4'd11:       return 8;
      default:           return 0;
    endcase
  endfunction

  // Reference: expected bus request and writeback value, built byte by byte.
  function automatic void model(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] rdata, output bit has_bus, output breq_t br, output res_t res);
    int          n   = op_bytes(op);
    int          off = int'(addr[2:0]);
    bit          sgn = (op >= 4'd1) && (op <= 4'd3);
    logic [63:0] v   = '0;
    br.addr = addr; br.size = '0; br.strobe = '0; br.wdata = '0;
    br.is_store = (op >= 4'd8) && (op <= 4'd11); br.rdata = rdata; br.delay = 0;
    res.data = '0; res.mis = 1'b0; has_bus = 1'b0;
    if (n == 0) begin
      res.data = wdata;
      return;
    end
`ifdef MEM_MISALIGN_TRAP_EN
    if ((off % n) != 0) begin
      res.data = addr;
      res.mis  = 1'b1;
      return;
    end
`endif
    has_bus = 1'b1;
    br.size = 3'($clog2(n));
    if (br.is_store) begin
      for (int b = 0; b < n; b++) if (off + b < 8) br.strobe[off + b] = 1'b1;
      br.wdata = (op == 4'd11) ? wdata : (wdata << (8 * off));
    end else begin
      for (int b = 0; b < n; b++) if (off + b < 8) v[8*b +: 8] = rdata[8*(off+b) +: 8];
      if (sgn && v[8*n-1]) for (int k = 8 * n; k < 64; k++) v[k] = 1'b1;
      res.data = v;
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int delay, input bit want_res,
                       input bit use_exp, input logic [63:0] exp_data, input logic exp_mis,
                       output bit acc_in_done);
    bit    hb;
    bit    acc = 1'b0;
    breq_t br;
    res_t  rs;
    model(op, addr, wdata, rdata, hb, br, rs);
    br.delay = delay;
    if (use_exp) begin
      rs.data = exp_data;
      rs.mis  = exp_mis;
    end
    acc_in_done  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_addr  = addr;
    bus.in_wdata = wdata;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) begin
        acc         = 1'b1;
        acc_in_done = bus.out_valid;
        if (hb) bus_q.push_back(br);
        if (want_res) exp_q.push_back(rs);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) timeout("accept");
  endtask

  task automatic settle();
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (bus_q.size() == 0) && !bus.dbus_valid && !bus.out_valid;
      @(posedge clk); #1;
    end
    if (!done) timeout("settle");
  endtask

  // WB-side ready driver.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      bus.out_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_fixed;
    end
  end

  // Data-bus responder: matches each request to the queued expectation and checks it stays stable.
  initial begin
    breq_t cur;
    bit    busy;
    int    cnt;
    busy = 1'b0;
    cnt  = 0;
    bus.dbus_data_ok = 1'b0;
    bus.dbus_rdata   = '0;
    forever begin
      @(posedge clk); #1;
      bus.dbus_data_ok = 1'b0;
      bus.dbus_rdata   = {$urandom, $urandom};
      if (reset_n && bus.dbus_valid) begin
        if (!busy) begin
          if (bus_q.size() == 0) begin
            timeout("unexpected_bus_request");
          end else begin
            cur  = bus_q.pop_front();
            busy = 1'b1;
            cnt  = cur.delay;
          end
        end
        if (busy) begin
          n_checks++;
          if (bus.dbus_addr !== cur.addr || bus.dbus_size !== cur.size || bus.dbus_strobe !== cur.strobe ||
              (cur.is_store && bus.dbus_wdata !== cur.wdata)) begin
            n_fail++;
            $display("FAIL bus_req: got addr=%h size=%0d strb=%h wdata=%h, expected addr=%h size=%0d strb=%h wdata=%h",
                     bus.dbus_addr, bus.dbus_size, bus.dbus_strobe, bus.dbus_wdata,
                     cur.addr, cur.size, cur.strobe, cur.wdata);
          end
          if (cnt == 0) begin
            bus.dbus_data_ok = 1'b1;
            bus.dbus_rdata   = cur.rdata;
            busy             = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Writeback monitor: pops the scoreboard on each handshake and checks results are held while stalled.
  initial begin
    bit          pv, pr, pf;
    logic [63:0] pd;
    res_t        e;
    pv = 1'b0; pr = 1'b0; pf = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (pv && !pr && !pf) begin
          check("out_hold_valid", bus.out_valid, 1);
          check("out_hold_data", bus.out_data, pd);
        end
        if (bus.out_valid && bus.out_ready && !bus.flush) begin
          if (exp_q.size() == 0) begin
            timeout("unexpected_out_valid");
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_misalign", bus.out_misalign, e.mis);
          end
        end
        pv = bus.out_valid; pr = bus.out_ready; pf = bus.flush; pd = bus.out_data;
      end else begin
        pv = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          aid;
    bit          seen;
    logic [3:0]  op;
    logic [63:0] addr;
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_addr = '0; bus.in_wdata = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dbus_valid", bus.dbus_valid, 0);
    check("rst_dbus_strobe", bus.dbus_strobe, 0);
    check("rst_dbus_wdata", bus.dbus_wdata, 0);
    check("rst_dbus_addr", bus.dbus_addr, 0);
    check("rst_dbus_size", bus.dbus_size, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_misalign", bus.out_misalign, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // LB sign-extended from lane 3, data_ok two cycles after valid.
    issue(4'd1, 64'h1003, 64'h0, 64'h00000000_80000000, 2, 1, 1, 64'hFFFFFFFF_FFFFFF80, 1'b0, aid);
    @(negedge clk);
    check("lb_dbus_valid_rise", bus.dbus_valid, 1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (c != 0) @(negedge clk);
      if (bus.dbus_data_ok) begin
        seen = 1'b1;
        check("lb_out_before_ok", bus.out_valid, 0);
        @(negedge clk);
        check("lb_out_latency", bus.out_valid, 1);
      end
    end
    if (!seen) timeout("lb_data_ok");
    @(posedge clk); #1;
    settle();

    // SH at lane 6: fields held until data_ok.
    issue(4'd9, 64'h2006, 64'hBEEF, 64'h0, 3, 1, 1, 64'h0, 1'b0, aid);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      check("sh_strobe", bus.dbus_strobe, 64'hC0);
      check("sh_wdata", bus.dbus_wdata, 64'hBEEF0000_00000000);
      check("sh_size", bus.dbus_size, 1);
      check("sh_addr", bus.dbus_addr, 64'h2006);
      seen = bus.dbus_data_ok;
    end
    if (!seen) timeout("sh_data_ok");
    @(posedge clk); #1;
    settle();

    // Back-to-back LWU then LD with single-cycle bus.
    issue(4'd7, 64'h10, 64'h0, 64'hFFFFFFFF_87654321, 0, 1, 1, 64'h00000000_87654321, 1'b0, aid);
    issue(4'd4, 64'h18, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1, 1, 64'h0123_4567_89AB_CDEF, 1'b0, aid);
    check("b2b_accept_in_done", aid, 1);
    settle();

    // Flush in REQ, response three cycles later.
    issue(4'd3, 64'h40, 64'h0, 64'h5555, 3, 0, 0, 64'h0, 1'b0, aid);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      check("drain_in_ready", bus.in_ready, 0);
      check("drain_dbus_valid", bus.dbus_valid, 1);
      seen = bus.dbus_data_ok;
    end
    if (!seen) timeout("drain_data_ok");
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_end_in_ready", bus.in_ready, 1);
    check("drain_end_out_valid", bus.out_valid, 0);
    check("drain_end_dbus_valid", bus.dbus_valid, 0);
    @(posedge clk); #1;

    // Flush in REQ coinciding with data_ok.
    issue(4'd4, 64'h80, 64'h0, 64'hAAAA, 0, 0, 0, 64'h0, 1'b0, aid);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_ok_in_ready", bus.in_ready, 1);
    check("flush_ok_out_valid", bus.out_valid, 0);
    check("flush_ok_dbus_valid", bus.dbus_valid, 0);
    @(posedge clk); #1;

    // Flush in DONE while WB stalls.
    rdy_fixed = 1'b0;
    issue(4'd0, 64'h0, 64'h1234, 64'h0, 0, 0, 0, 64'h0, 1'b0, aid);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_done_out_valid", bus.out_valid, 0);
    check("flush_done_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // WB stalled 4 cycles on a pass-through result.
    issue(4'd0, 64'h0, 64'hA5A5_0123_4567_89AB, 64'h0, 0, 1, 1, 64'hA5A5_0123_4567_89AB, 1'b0, aid);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data", bus.out_data, 64'hA5A5_0123_4567_89AB);
      check("stall_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    rdy_fixed = 1'b1;
    settle();

    // Misaligned LW and SW at 0x1002.
`ifdef MEM_MISALIGN_TRAP_EN
    issue(4'd3, 64'h1002, 64'h0, 64'h0, 0, 1, 1, 64'h1002, 1'b1, aid);
    @(negedge clk);
    check("trap_no_bus", bus.dbus_valid, 0);
    check("trap_out_valid", bus.out_valid, 1);
    check("trap_flag", bus.out_misalign, 1);
    @(posedge clk); #1;
    settle();
    @(negedge clk);
    check("trap_flag_clear", bus.out_misalign, 0);
    @(posedge clk); #1;
    issue(4'd10, 64'h1002, 64'hCAFEF00D, 64'h0, 0, 1, 1, 64'h1002, 1'b1, aid);
    settle();
`else
    issue(4'd3, 64'h1002, 64'h0, 64'h11223344_55667788, 1, 1, 1, 64'h00000000_33445566, 1'b0, aid);
    @(negedge clk);
    check("mis_lw_valid", bus.dbus_valid, 1);
    check("mis_lw_strobe", bus.dbus_strobe, 0);
    check("mis_flag", bus.out_misalign, 0);
    @(posedge clk); #1;
    settle();
    issue(4'd10, 64'h1002, 64'hCAFEF00D, 64'h0, 0, 1, 1, 64'h0, 1'b0, aid);
    @(negedge clk);
    check("mis_sw_strobe", bus.dbus_strobe, 64'h3C);
    check("mis_sw_wdata", bus.dbus_wdata, 64'h0000CAFE_F00D0000);
    check("mis_sw_size", bus.dbus_size, 2);
    @(posedge clk); #1;
    settle();
`endif

    // Randomized traffic with random WB backpressure and bus wait states.
    rdy_rand = 1'b1;
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      op   = 4'($urandom_range(0, 15));
      addr = {$urandom, $urandom};
      if ($urandom_range(1) == 0) addr[2:0] = 3'd0;
      issue(op, addr, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), 1, 0, 64'h0, 1'b0, aid);
    end
    rdy_rand = 1'b0;
    settle();

    check("exp_q_empty", exp_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
